counter_scheduler: RTL and testbench

- Round-robin scheduler that shares one loadable N-bit up-counter (set/count-enable/data in, Q out) between REQS requesters.
- Each requester supplies a start value and an end value. The scheduler grants one requester at a time, loads the counter, gates counting with a tick strobe until Q equals the end value, then pulses that requester's done.
- Sits between the requesting control blocks and the shared counter instance; counter and scheduler run on the same clock.

---
 rtl/counter_scheduler.sv | 133 +++++++++++++
 tb/tb_counter_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared loadable up-counter: load start, count on tick to end, pulse done.
// Request to grant in 1 cycle. A dropped request aborts the job and releases the counter.
module counter_scheduler #(
    parameter int N    = 4,
    parameter int REQS = 4
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              tick,
    input  logic [REQS-1:0]   req,
    input  logic [REQS*N-1:0] start_val,
    input  logic [REQS*N-1:0] end_val,
    input  logic [N-1:0]      cnt_q,
    output logic              cnt_set,
    output logic [N-1:0]      cnt_data,
    output logic              cnt_en,
    output logic [REQS-1:0]   grant,
    output logic [REQS-1:0]   done,
    output logic              busy
);
    localparam int IW = $clog2(REQS);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] owner_inc;
    logic [IW-1:0] pick;
    logic          found;
    logic          at_end;
    logic [N-1:0]  start_arr [REQS];
    logic [N-1:0]  end_arr   [REQS];
    logic [N-1:0]  start_cur, end_cur;

    for (genvar i = 0; i < REQS; i++) begin : g_unpack
        assign start_arr[i] = start_val[i*N +: N];
        assign end_arr[i]   = end_val[i*N +: N];
    end

    assign start_cur = start_arr[owner];
    assign end_cur   = end_arr[owner];
    assign at_end    = (cnt_q == end_cur);
    assign owner_inc = (owner == IW'(REQS - 1)) ? '0 : owner + IW'(1);

    // First set request at or above the pointer, wrapping past the top requester.
    always_comb begin
        logic [IW:0] idx;
        idx   = '0;
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < REQS; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(REQS)) begin
                idx = idx - (IW+1)'(REQS);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // A withdrawn request wins over reaching the end value in the same cycle.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOAD;
                    owner_nxt = pick;
                end
            end
            LOAD: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner_inc;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner_inc;
                end else if (at_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ptr_nxt   = owner_inc;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        done     = '0;
        busy     = 1'b0;
        cnt_set  = 1'b0;
        cnt_data = '0;
        cnt_en   = 1'b0;
        if (state != IDLE) begin
            grant[owner] = 1'b1;
            busy         = 1'b1;
        end
        case (state)
            LOAD: begin
                cnt_set  = 1'b1;
                cnt_data = start_cur;
            end
            RUN:     cnt_en = tick & ~at_end;
            DONE:    done[owner] = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_counter_scheduler.sv
// Drives the scheduler with a bench-side shared counter and compares every cycle to a job-level model.
module tb_counter_scheduler;
    localparam int N    = 4;
    localparam int REQS = 4;
    localparam int IW   = 2;
    localparam int W    = 2*REQS + 2*N + 3;

    logic              CLK100MHZ = 1'b0;
    logic              reset;
    logic              tick;
    logic [REQS-1:0]   req;
    logic [REQS*N-1:0] start_val;
    logic [REQS*N-1:0] end_val;
    logic [N-1:0]      cnt_q = '0;
    logic              cnt_set;
    logic [N-1:0]      cnt_data;
    logic              cnt_en;
    logic [REQS-1:0]   grant;
    logic [REQS-1:0]   done;
    logic              busy;

    logic [N-1:0] s_arr [REQS];
    logic [N-1:0] e_arr [REQS];

    int vectors     = 0;
    int miscompares = 0;

    // Model state: current job owner (-1 when free), its phase, pointer and counter value.
    int m_owner     = -1;
    bit m_loading   = 1'b0;
    bit m_finishing = 1'b0;
    int m_ptr       = 0;
    int m_q         = 0;

    for (genvar i = 0; i < REQS; i++) begin : g_pack
        assign start_val[i*N +: N] = s_arr[i];
        assign end_val[i*N +: N]   = e_arr[i];
    end

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) begin
        if (cnt_set) cnt_q <= cnt_data;
        else if (cnt_en) cnt_q <= cnt_q + N'(1);
    end

    counter_scheduler #(.N(N), .REQS(REQS)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .tick      (tick),
        .req       (req),
        .start_val (start_val),
        .end_val   (end_val),
        .cnt_q     (cnt_q),
        .cnt_set   (cnt_set),
        .cnt_data  (cnt_data),
        .cnt_en    (cnt_en),
        .grant     (grant),
        .done      (done),
        .busy      (busy)
    );

    function automatic logic [IW-1:0] ix(input int i);
        return i[IW-1:0];
    endfunction

    function automatic int remaining();
        return (int'(e_arr[ix(m_owner)]) - m_q) & ((1 << N) - 1);
    endfunction

    function automatic logic [W-1:0] outs();
        return {grant, done, busy, cnt_set, cnt_data, cnt_en, cnt_q};
    endfunction

    function automatic logic [W-1:0] model_exp();
        logic [REQS-1:0] g, d;
        logic            b, s, en;
        logic [N-1:0]    dat;
        g = '0; d = '0; b = 1'b0; s = 1'b0; en = 1'b0; dat = '0;
        if (m_owner >= 0) begin
            g[ix(m_owner)] = 1'b1;
            b = 1'b1;
            if (m_loading) begin
                s   = 1'b1;
                dat = s_arr[ix(m_owner)];
            end else if (m_finishing) begin
                d[ix(m_owner)] = 1'b1;
            end else begin
                en = tick && (remaining() != 0);
            end
        end
        return {g, d, b, s, dat, en, N'(m_q)};
    endfunction

    // Advance the model across one clock edge using the inputs currently applied, then step the clock.
    task automatic advance();
        bit running, en;
        int rem;
        running = (m_owner >= 0) && !m_loading && !m_finishing;
        rem     = running ? remaining() : 0;
        en      = running && tick && (rem != 0);
        if (m_owner >= 0 && m_loading) m_q = int'(s_arr[ix(m_owner)]);
        else if (en) m_q = (m_q + 1) & ((1 << N) - 1);
        if (reset) begin
            m_owner = -1; m_loading = 1'b0; m_finishing = 1'b0; m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < REQS; k++) begin
                if (m_owner < 0 && req[ix((m_ptr + k) % REQS)]) begin
                    m_owner   = (m_ptr + k) % REQS;
                    m_loading = 1'b1;
                end
            end
        end else if (m_finishing) begin
            m_ptr = (m_owner + 1) % REQS; m_owner = -1; m_finishing = 1'b0;
        end else if (!req[ix(m_owner)]) begin
            m_ptr = (m_owner + 1) % REQS; m_owner = -1; m_loading = 1'b0;
        end else if (m_loading) begin
            m_loading = 1'b0;
        end else if (rem == 0) begin
            m_finishing = 1'b1;
        end
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        reset = 1'b1; tick = 1'b1; req = REQS'($urandom);
        for (int i = 0; i < REQS; i++) begin
            s_arr[i] = N'($urandom); e_arr[i] = N'($urandom);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            req = REQS'($urandom);
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL reset c%0d: got %h want %h", c, outs(), exp);
            end
            vectors++;
            if ({grant, done, busy, cnt_set, cnt_data, cnt_en} !== '0) begin
                miscompares++; $display("FAIL reset_zero c%0d: got %h want 0", c, outs());
            end
            advance();
        end
        reset = 1'b0; req = '0;
    endtask

    task automatic test_single();
        logic [W-1:0] exp;
        int en_cnt = 0, done_cnt = 0, set_cnt = 0;
        s_arr[0] = N'(2); e_arr[0] = N'(5); tick = 1'b1; req = REQS'(1);
        for (int c = 0; c < 10; c++) begin
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL single c%0d: got %h want %h", c, outs(), exp);
            end
            if (c == 1) begin
                vectors++;
                if (grant !== REQS'(1)) begin
                    miscompares++; $display("FAIL single_grant: got %b want 0001", grant);
                end
            end
            if (cnt_en) en_cnt++;
            if (done[0]) begin
                done_cnt++;
                vectors++;
                if (cnt_q !== N'(5)) begin
                    miscompares++; $display("FAIL single_done_q: got %0d want 5", cnt_q);
                end
                req[0] = 1'b0;
            end
            if (cnt_set && cnt_data == N'(2)) set_cnt++;
            advance();
        end
        vectors++;
        if (en_cnt != 3 || done_cnt != 1 || set_cnt != 1) begin
            miscompares++;
            $display("FAIL single_counts: got en=%0d done=%0d set=%0d want 3 1 1", en_cnt, done_cnt, set_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp;
        logic [N-1:0] qs[$];
        logic [N-1:0] want [4];
        int en_cnt = 0;
        want[0] = N'(14); want[1] = N'(15); want[2] = N'(0); want[3] = N'(1);
        s_arr[0] = N'(14); e_arr[0] = N'(1); tick = 1'b1; req = REQS'(1);
        for (int c = 0; c < 10; c++) begin
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL wrap c%0d: got %h want %h", c, outs(), exp);
            end
            if (busy && !cnt_set && done == '0) qs.push_back(cnt_q);
            if (cnt_en) en_cnt++;
            if (done[0]) req[0] = 1'b0;
            advance();
        end
        vectors++;
        if (qs.size() != 4 || en_cnt != 3) begin
            miscompares++; $display("FAIL wrap_len: got %0d run cycles %0d counts want 4 3", qs.size(), en_cnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (qs[i] !== want[i]) begin
                    miscompares++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, qs[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_equal();
        logic [W-1:0] exp;
        int en_cnt = 0, c_set = -1, c_done = -1;
        s_arr[0] = N'(7); e_arr[0] = N'(7); tick = 1'b1; req = REQS'(1);
        for (int c = 0; c < 8; c++) begin
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL equal c%0d: got %h want %h", c, outs(), exp);
            end
            if (cnt_en) en_cnt++;
            if (cnt_set) c_set = c;
            if (done[0]) begin c_done = c; req[0] = 1'b0; end
            advance();
        end
        vectors++;
        if (en_cnt != 0 || c_set < 0 || c_done - c_set != 2) begin
            miscompares++; $display("FAIL equal_timing: got en=%0d gap=%0d want 0 2", en_cnt, c_done - c_set);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp;
        logic [REQS-1:0] gq[$];
        logic [REQS-1:0] want [5];
        logic [REQS-1:0] prev = '0;
        int done_cnt = 0;
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
        reset = 1'b1; advance(); reset = 1'b0;
        for (int i = 0; i < REQS; i++) begin s_arr[i] = N'(0); e_arr[i] = N'(1); end
        tick = 1'b1; req = '1;
        for (int c = 0; c < 26; c++) begin
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL rr c%0d: got %h want %h", c, outs(), exp);
            end
            vectors++;
            if ($countones(grant) > 1 || (done != '0 && done !== grant)) begin
                miscompares++; $display("FAIL rr_onehot c%0d: got grant=%b done=%b want one-hot", c, grant, done);
            end
            if (prev == '0 && grant != '0) gq.push_back(grant);
            if (done != '0) done_cnt++;
            prev = grant;
            advance();
        end
        vectors++;
        if (gq.size() != 5 || done_cnt != 5) begin
            miscompares++; $display("FAIL rr_count: got %0d grants %0d dones want 5 5", gq.size(), done_cnt);
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (gq[i] !== want[i]) begin
                    miscompares++; $display("FAIL rr_order[%0d]: got %b want %b", i, gq[i], want[i]);
                end
            end
        end
        req = '0; advance(); advance();
    endtask

    task automatic test_tick_gating();
        logic [W-1:0] exp;
        int en_cnt = 0, done_cnt = 0;
        s_arr[2] = N'(0); e_arr[2] = N'(3); req = 4'b0100;
        for (int c = 0; c < 24; c++) begin
            tick = (c % 4 == 3);
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL tick c%0d: got %h want %h", c, outs(), exp);
            end
            vectors++;
            if (cnt_en && !tick) begin
                miscompares++; $display("FAIL tick_gate c%0d: got cnt_en=1 want 0 without tick", c);
            end
            if (cnt_en) en_cnt++;
            if (done[2]) begin done_cnt++; req[2] = 1'b0; end
            advance();
        end
        vectors++;
        if (en_cnt != 3 || done_cnt != 1) begin
            miscompares++; $display("FAIL tick_counts: got en=%0d done=%0d want 3 1", en_cnt, done_cnt);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] exp;
        int done_cnt = 0;
        reset = 1'b1; advance(); reset = 1'b0;
        s_arr[1] = N'(0); e_arr[1] = N'(10); tick = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req = (c < 4) ? 4'b0010 : (c < 7 && c > 4) ? 4'b1101 : 4'b0000;
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL abort c%0d: got %h want %h", c, outs(), exp);
            end
            if (c == 5) begin
                vectors++;
                if (grant !== '0) begin
                    miscompares++; $display("FAIL abort_release: got %b want 0000", grant);
                end
            end
            if (c == 6) begin
                vectors++;
                if (grant !== 4'b0100) begin
                    miscompares++; $display("FAIL abort_ptr: got %b want 0100", grant);
                end
            end
            if (done != '0) done_cnt++;
            advance();
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] exp;
        s_arr[2] = N'(0); e_arr[2] = N'(12); tick = 1'b1;
        for (int c = 0; c < 9; c++) begin
            reset = (c == 4);
            req   = (c < 5) ? 4'b0100 : (c < 7) ? 4'b1001 : 4'b0000;
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL rst_run c%0d: got %h want %h", c, outs(), exp);
            end
            if (c == 5) begin
                vectors++;
                if ({grant, done, busy, cnt_set, cnt_data, cnt_en} !== '0) begin
                    miscompares++; $display("FAIL rst_run_zero: got %h want 0", outs());
                end
            end
            if (c == 6) begin
                vectors++;
                if (grant !== 4'b0001) begin
                    miscompares++; $display("FAIL rst_run_ptr: got %b want 0001", grant);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        for (int c = 0; c < 800; c++) begin
            tick  = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < REQS; i++) begin
                if (m_owner == i) begin
                    if (m_finishing) req[ix(i)] = ($urandom_range(0, 1) == 1);
                    else if ($urandom_range(0, 39) == 0) req[ix(i)] = 1'b0;
                end else begin
                    if ($urandom_range(0, 4) == 0) req[ix(i)] = ~req[ix(i)];
                    s_arr[i] = N'($urandom);
                    e_arr[i] = N'($urandom);
                end
            end
            #1;
            exp = model_exp();
            vectors++;
            if (outs() !== exp) begin
                miscompares++; $display("FAIL random c%0d: got %h want %h", c, outs(), exp);
            end
            advance();
        end
        reset = 1'b0; req = '0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; req = '0;
        for (int i = 0; i < REQS; i++) begin s_arr[i] = '0; e_arr[i] = '0; end
        test_reset();
        test_single();
        test_wrap();
        test_equal();
        test_round_robin();
        test_tick_gating();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
